// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width and
// the clock/baud constants shared with uart_tx.
package uart_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned UART_DATA_WIDTH   = 8;
    localparam int unsigned UART_CLK_FREQ_HZ  = 50_000_000;
    localparam int unsigned UART_BAUD_RATE    = 115_200;
    localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_FREQ_HZ / UART_BAUD_RATE;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr+1,
// wrapping modulo P_NUM_REQ.
module rr_arbiter #(
    parameter int unsigned P_NUM_REQ = 4,
    parameter int unsigned P_ID_W    = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [P_ID_W-1:0]    ptr,
    output logic                 pick_valid,
    output logic [P_ID_W-1:0]    pick_id
);

    function automatic logic [P_ID_W-1:0] wrap_idx(input int unsigned n);
        return P_ID_W'(n % P_NUM_REQ);
    endfunction

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        // Offset P_NUM_REQ lands back on ptr itself, so it is checked last.
        for (int unsigned i = 1; i <= P_NUM_REQ; i++) begin
            if (!pick_valid && req[wrap_idx(32'(ptr) + i)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_idx(32'(ptr) + i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx byte port between
// P_NUM_REQ requesters, with a one-entry output register.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned P_NUM_REQ         = 4,
    parameter int unsigned P_UART_DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned P_MAX_BURST       = 16,
    localparam int unsigned ID_W             = $clog2(P_NUM_REQ)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [P_NUM_REQ*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]                 i_req_valid,
    input  logic [P_NUM_REQ-1:0]                 i_req_last,
    output logic [P_NUM_REQ-1:0]                 o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]         o_user_tx_data,
    output logic                                 o_user_tx_valid,
    input  logic                                 i_user_tx_ready,
    output logic                                 o_grant_valid,
    output logic [ID_W-1:0]                      o_grant_id
);

    localparam int unsigned CNT_W = $clog2(P_MAX_BURST + 1);

    arb_state_e                   state_q, state_d;
    logic [ID_W-1:0]              grant_id_q, grant_id_d;
    logic [CNT_W-1:0]             burst_cnt_q, burst_cnt_d, burst_inc;
    logic                         out_valid_q, out_valid_d;
    logic [P_UART_DATA_WIDTH-1:0] out_data_q, out_data_d, sel_data;
    logic                         granted_q, granted_d;
    logic                         pick_valid, sel_last, req_xfer, uart_xfer;
    logic [ID_W-1:0]              pick_id;
    logic [P_NUM_REQ-1:0]         req_ready;

    rr_arbiter #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (i_req_valid),
        .ptr        (grant_id_q),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    always_comb begin
        sel_data  = i_req_data[grant_id_q*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
        sel_last  = i_req_last[grant_id_q];
        burst_inc = burst_cnt_q + CNT_W'(1);

        req_ready = '0;
        if (state_q == S_BUSY) begin
            req_ready[grant_id_q] = ~out_valid_q | i_user_tx_ready;
        end
        req_xfer  = |(i_req_valid & req_ready);
        uart_xfer = out_valid_q & i_user_tx_ready;

        state_d     = state_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        granted_d   = granted_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                    granted_d   = 1'b1;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (req_xfer) begin
                    burst_cnt_d = burst_inc;
                    if (sel_last || burst_inc == CNT_W'(P_MAX_BURST)) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        // A load in the same cycle as a UART accept replaces the byte.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (req_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (uart_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            grant_id_q  <= ID_W'(P_NUM_REQ - 1);
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            granted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            granted_q   <= granted_d;
        end
    end

    assign o_req_ready     = req_ready;
    assign o_user_tx_data  = out_data_q;
    assign o_user_tx_valid = out_valid_q;
    assign o_grant_valid   = (state_q == S_BUSY);
    // The pointer resets to the last index, but the visible id reads 0 until
    // a first grant has actually been made.
    assign o_grant_id      = granted_q ? grant_id_q : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, expected
// UART byte order queue, and per-scenario timing/protocol checks.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [W-1:0]      tx_data;
    logic              tx_valid, tx_ready, grant_valid;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .P_NUM_REQ         (NREQ),
        .P_UART_DATA_WIDTH (W),
        .P_MAX_BURST       (16)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst_n),
        .i_req_data      (req_data),
        .i_req_valid     (req_valid),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_user_tx_data  (tx_data),
        .o_user_tx_valid (tx_valid),
        .i_user_tx_ready (tx_ready),
        .o_grant_valid   (grant_valid),
        .o_grant_id      (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] src_q [NREQ][$];  // {last, data}
    logic [7:0] exp_q [$];
    int         xfer_cyc [$];
    bit         gv_log [512];
    int         first_valid_cyc;
    int         ur_mode;
    bit         chk_lock;
    int         gap_after [NREQ];
    int         gap_left [NREQ];
    int         sent [NREQ];
    bit         pkt_open [NREQ];
    int         gap_seen;
    int         cyc;

    task automatic clear_tb();
        for (int k = 0; k < NREQ; k++) begin
            src_q[k].delete();
            gap_after[k] = -1;
            gap_left[k]  = 0;
            sent[k]      = 0;
            pkt_open[k]  = 1'b0;
        end
        exp_q.delete();
        xfer_cyc.delete();
        for (int i = 0; i < 512; i++) gv_log[i] = 1'b0;
        first_valid_cyc = -1;
        ur_mode  = 0;
        chk_lock = 1'b0;
        gap_seen = 0;
        cyc      = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_tb();
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() > 0 && sent[k] == gap_after[k] && gap_left[k] > 0) begin
                gap_left[k]--;
                req_valid[k]        = 1'b0;
                req_data[k*W +: W]  = '0;
                req_last[k]         = 1'b0;
            end else if (src_q[k].size() > 0) begin
                h = src_q[k][0];
                req_valid[k]        = 1'b1;
                req_data[k*W +: W]  = h[7:0];
                req_last[k]         = h[8];
            end else begin
                req_valid[k]        = 1'b0;
                req_data[k*W +: W]  = '0;
                req_last[k]         = 1'b0;
            end
        end
        tx_ready = (ur_mode == 0) ? 1'b1 : (cyc % 10 == 9);
    endtask

    function automatic bit sources_busy();
        for (int k = 0; k < NREQ; k++) if (src_q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Drive sources, sample at negedge, pop on accepted handshakes.
    task automatic run(input int budget);
        logic [NREQ-1:0] xf;
        logic [8:0]      e9;
        logic [7:0]      e;
        logic [7:0]      hold_data;
        bit              hold, bad;
        cyc  = 0;
        hold = 1'b0;
        drive_inputs();
        while ((sources_busy() || exp_q.size() > 0 || tx_valid) && cyc < budget) begin
            @(negedge clk);
            if (cyc < 512) gv_log[cyc] = grant_valid;
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            xf = req_valid & req_ready;

            checks++;
            if ($countones(req_ready) > 1)
                $display("FAIL ready_onehot: got %b required at most one bit", req_ready);
            if ($countones(req_ready) > 1) failures++;

            if (tx_valid && !tx_ready) begin
                checks++;
                if (req_ready !== '0) begin
                    failures++;
                    $display("FAIL ready_while_full: got %b required 0000", req_ready);
                end
            end
            if (hold) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
                    failures++;
                    $display("FAIL tx_stable: got valid=%b data=%h required valid=1 data=%h",
                             tx_valid, tx_data, hold_data);
                end
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;

            if (chk_lock) begin
                bad = 1'b0;
                for (int k = 0; k < NREQ; k++)
                    for (int j = 0; j < NREQ; j++)
                        if (req_ready[k] && j != k && pkt_open[j]) bad = 1'b1;
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL packet_lock: got ready=%b while another packet open", req_ready);
                end
            end

            for (int k = 0; k < NREQ; k++) begin
                if (src_q[k].size() > 0 && !req_valid[k] && sent[k] == gap_after[k]) begin
                    gap_seen++;
                    checks++;
                    if (!(grant_valid && grant_id == 2'(k))) begin
                        failures++;
                        $display("FAIL grant_held: got valid=%b id=%0d required valid=1 id=%0d",
                                 grant_valid, grant_id, k);
                    end
                end
            end

            if (tx_valid && tx_ready) begin
                xfer_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got %h required none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL tx_byte: got %h required %h", tx_data, e);
                    end
                end
            end

            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < NREQ; k++) begin
                if (xf[k]) begin
                    e9 = src_q[k].pop_front();
                    sent[k]++;
                    pkt_open[k] = !e9[8];
                end
            end
            drive_inputs();
        end
        checks++;
        if (sources_busy() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d bytes outstanding required 0 within %0d cycles",
                     exp_q.size(), budget);
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = 32'h13121110;
        req_last  = '1;
        tx_ready  = 1'b1;
        #3;
        checks++;
        if ({req_ready, tx_data, tx_valid, grant_valid, grant_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b data=%h valid=%b gv=%b gid=%0d required all 0",
                     req_ready, tx_data, tx_valid, grant_valid, grant_id);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL idle_ready: got %b required 0000", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL first_grant: got gv=%b id=%0d required gv=1 id=0", grant_valid, grant_id);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL first_ready: got %b required 0001", req_ready);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        src_q[0] = '{9'h041, 9'h042, 9'h143};
        exp_q    = '{8'h41, 8'h42, 8'h43};
        run(50);
        checks++;
        if (first_valid_cyc != 2) begin
            failures++;
            $display("FAIL single_latency: got %0d required 2", first_valid_cyc);
        end
        checks++;
        if (xfer_cyc.size() != 3 || xfer_cyc[0] != 2 || xfer_cyc[1] != 3 || xfer_cyc[2] != 4) begin
            failures++;
            $display("FAIL single_b2b: got %0d transfers first at %0d required 3 at 2,3,4",
                     xfer_cyc.size(), (xfer_cyc.size() > 0) ? xfer_cyc[0] : -1);
        end
        checks++;
        if (gv_log[1] !== 1'b1 || gv_log[3] !== 1'b1 || gv_log[4] !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got gv1=%b gv3=%b gv4=%b required 1 1 0",
                     gv_log[1], gv_log[3], gv_log[4]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        src_q[0] = '{9'h110, 9'h110};
        src_q[1] = '{9'h111};
        src_q[2] = '{9'h112};
        src_q[3] = '{9'h113};
        exp_q    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        run(100);
    endtask

    task automatic test_max_burst();
        do_reset();
        for (int i = 0; i < 20; i++) src_q[1].push_back({i == 19, 8'(8'h80 + i)});
        src_q[2] = '{9'h0A0, 9'h0A1, 9'h1A2};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
        run(200);
    endtask

    task automatic test_backpressure();
        do_reset();
        ur_mode  = 1;
        src_q[0] = '{9'h031, 9'h032, 9'h133};
        src_q[2] = '{9'h0C4, 9'h1C5};
        exp_q    = '{8'h31, 8'h32, 8'h33, 8'hC4, 8'hC5};
        run(400);
    endtask

    task automatic test_reset_mid_packet();
        bit seen;
        do_reset();
        req_valid[0]    = 1'b1;
        req_data[7:0]   = 8'h77;
        req_last[0]     = 1'b0;
        tx_ready        = 1'b0;
        seen            = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_fill: got tx_valid=0 required 1 within 10 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, tx_data, tx_valid, grant_valid, grant_id} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got ready=%b data=%h valid=%b gv=%b gid=%0d required all 0",
                     req_ready, tx_data, tx_valid, grant_valid, grant_id);
        end
        req_valid = '0;
        req_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_tb();
        src_q[3] = '{9'h166};
        src_q[0] = '{9'h155};
        exp_q    = '{8'h55, 8'h66};
        run(50);
    endtask

    task automatic test_hold_grant();
        do_reset();
        chk_lock     = 1'b1;
        src_q[0]     = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h1D3};
        gap_after[0] = 2;
        gap_left[0]  = 5;
        src_q[3]     = '{9'h1E0};
        exp_q        = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0};
        run(100);
        checks++;
        if (gap_seen != 5) begin
            failures++;
            $display("FAIL gap_cycles: got %0d required 5", gap_seen);
        end
    endtask

    initial begin
        clear_tb();
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid_packet();
        test_hold_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
